// File: rtl/seq_logic_pkg.sv
// Shared opcode constants and FSM state encoding for the slice-serial logic unit.
package seq_logic_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_XNOR = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// One SLICE-wide bitwise logic operator, shared by every slice position of the unit.
module logic_slice
    import seq_logic_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op_sel,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op_sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_NOTA: y = ~a;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/seq_logic_unit.sv
// Slice-serial logic unit: latches operands on start, then evaluates one SLICE per
// cycle LSB-first into y, pulsing done for one cycle once the whole word is written.
module seq_logic_unit
    import seq_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             state;
    state_e             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE-1:0]   y_sl;
    logic               accept;
    logic               last;

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign accept = op_start && (state != ST_RUN);
    assign last   = (cnt == CNT_W'(N - 1));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (op_start) state_nx = ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = op_start ? ST_RUN : ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Constant-index mux keeps the slice selection free of variable-width arithmetic.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a      (a_sl),
        .b      (b_sl),
        .op_sel (op_q),
        .y      (y_sl)
    );

    // Operand registers carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            y     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt == CNT_W'(k)) y[k*SLICE +: SLICE] <= y_sl;
                end
                if (!last) cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
